// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor: FSM state encoding, coin
// denomination codes and their credit values, credit width and ceiling.
package coin_acceptor_pkg;

    localparam int unsigned CREDIT_W   = 5;
    localparam int unsigned CREDIT_MAX = 31;
    localparam int unsigned COIN_VAL_W = 2;

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_START    = 2'd1,
        ST_RUN      = 2'd2,
        ST_WAIT_CLR = 2'd3
    } state_e;

    typedef enum logic [COIN_VAL_W-1:0] {
        COIN_1  = 2'b00,
        COIN_2  = 2'b01,
        COIN_5  = 2'b10,
        COIN_10 = 2'b11
    } coin_e;

    localparam logic [CREDIT_W-1:0] COIN_1_VAL  = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] COIN_2_VAL  = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] COIN_5_VAL  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] COIN_10_VAL = CREDIT_W'(10);

    // Credit units for a denomination code.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [COIN_VAL_W-1:0] code);
        logic [CREDIT_W-1:0] val;
        case (code)
            COIN_1:  val = COIN_1_VAL;
            COIN_2:  val = COIN_2_VAL;
            COIN_5:  val = COIN_5_VAL;
            default: val = COIN_10_VAL;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// Coin event front end: optional 2-flop input synchronizer plus rising-edge
// detector on coin_det.
//   Build option: define COIN_SYNC_EN to synchronize coin_det, coin_val and
//   cancel through two flops before use; otherwise inputs are used directly.
//   Ports: clk, rst_n          - clock, async active-low reset
//          coin_det/coin_val   - raw coin sensor and denomination
//          cancel              - raw cancel level
//          coin_evt_c          - one-cycle coin event (combinational)
//          coin_val_c/cancel_c - denomination/cancel aligned with coin_evt_c
module coin_edge_detect
    import coin_acceptor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coin_det,
    input  logic [COIN_VAL_W-1:0] coin_val,
    input  logic                  cancel,
    output logic                  coin_evt_c,
    output logic [COIN_VAL_W-1:0] coin_val_c,
    output logic                  cancel_c
);

    localparam int unsigned SYNC_W = COIN_VAL_W + 2;

    logic det_s;

`ifdef COIN_SYNC_EN
    // Edges only become trustworthy once the sync pipe and prev flop hold real samples.
    localparam int unsigned ARM_CYC = 3;

    logic [SYNC_W-1:0] sync1_q, sync1_d;
    logic [SYNC_W-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {cancel, coin_val, coin_det};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign det_s      = sync2_q[0];
    assign coin_val_c = sync2_q[SYNC_W-2:1];
    assign cancel_c   = sync2_q[SYNC_W-1];
`else
    localparam int unsigned ARM_CYC = 1;

    assign det_s      = coin_det;
    assign coin_val_c = coin_val;
    assign cancel_c   = cancel;
`endif

    logic       prev_q, prev_d;
    logic [1:0] arm_q, arm_d;
    logic       armed_c;

    // A level already high when reset releases must not read as a coin.
    always_comb begin
        armed_c    = (arm_q == 2'(ARM_CYC));
        arm_d      = armed_c ? arm_q : arm_q + 2'd1;
        prev_d     = det_s;
        coin_evt_c = det_s & ~prev_q & armed_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            arm_q  <= 2'd0;
        end else begin
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor for a washing machine: accumulates coin credit, starts a
// wash at PRICE, returns change, refunds on cancel or idle timeout.
//   Build option: COIN_SYNC_EN adds an input synchronizer (see coin_edge_detect).
//   Ports: clk, rst_n        - clock, async active-low reset
//          coin_det/coin_val - coin sensor edge and denomination
//          cancel            - refund request level
//          wash_done         - completion level from machine controller
//          coin_in           - one-cycle wash start pulse
//          credit            - accumulated credit
//          busy              - wash in progress
//          change_valid/amt  - one-cycle change/refund payout
//          coin_reject       - one-cycle pulse for a refused coin
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int unsigned PRICE       = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coin_det,
    input  logic [COIN_VAL_W-1:0] coin_val,
    input  logic                  cancel,
    input  logic                  wash_done,
    output logic                  coin_in,
    output logic [CREDIT_W-1:0]   credit,
    output logic                  busy,
    output logic                  change_valid,
    output logic [CREDIT_W-1:0]   change_amt,
    output logic                  coin_reject
);

    localparam int unsigned IDLE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W:0]   SUM_MAX   = (CREDIT_W+1)'(CREDIT_MAX);

    logic                  coin_evt_c;
    logic [COIN_VAL_W-1:0] coin_val_c;
    logic                  cancel_c;

    coin_edge_detect u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_det   (coin_det),
        .coin_val   (coin_val),
        .cancel     (cancel),
        .coin_evt_c (coin_evt_c),
        .coin_val_c (coin_val_c),
        .cancel_c   (cancel_c)
    );

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  coin_in_q, coin_in_d;
    logic                  busy_q, busy_d;
    logic                  change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]   change_amt_q, change_amt_d;
    logic                  coin_reject_q, coin_reject_d;

    logic [CREDIT_W:0]     sum_c;
    logic                  fits_c;
    logic [CREDIT_W-1:0]   total_c;

    // Next state, credit and registered outputs.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        idle_d         = idle_q;
        coin_in_d      = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        coin_reject_d  = 1'b0;

        sum_c   = {1'b0, credit_q} + {1'b0, coin_value(coin_val_c)};
        fits_c  = (sum_c <= SUM_MAX);
        // Credit including this cycle's coin when it is accepted.
        total_c = (coin_evt_c && fits_c) ? sum_c[CREDIT_W-1:0] : credit_q;

        case (state_q)
            ST_ACCUM: begin
                if (credit_q >= PRICE_C) begin
                    // Price already reached: start; a coin landing now is refused.
                    state_d       = ST_START;
                    coin_in_d     = 1'b1;
                    credit_d      = '0;
                    idle_d        = '0;
                    coin_reject_d = coin_evt_c;
                    if (credit_q > PRICE_C) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q - PRICE_C;
                    end
                end else begin
                    coin_reject_d = coin_evt_c & ~fits_c;
                    if (cancel_c && (total_c != '0)) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = total_c;
                        credit_d       = '0;
                        idle_d         = '0;
                    end else if (!coin_evt_c && (credit_q != '0) && (idle_q == IDLE_LAST)) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                        idle_d         = '0;
                    end else begin
                        credit_d = total_c;
                        idle_d   = (coin_evt_c || (credit_q == '0)) ? '0 : idle_q + IDLE_W'(1);
                    end
                end
            end
            ST_START: begin
                state_d       = ST_RUN;
                coin_reject_d = coin_evt_c;
            end
            ST_RUN: begin
                coin_reject_d = coin_evt_c;
                if (wash_done) state_d = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                coin_reject_d = coin_evt_c;
                if (!wash_done) state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_WAIT_CLR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_ACCUM;
            credit_q       <= '0;
            idle_q         <= '0;
            coin_in_q      <= 1'b0;
            busy_q         <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            idle_q         <= idle_d;
            coin_in_q      <= coin_in_d;
            busy_q         <= busy_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign coin_in      = coin_in_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: two instances (PRICE 4 and 28, short timeout)
// share random stimulus and are compared every cycle against a
// cycle-level behavioural model, plus directed scenario checks.
module tb_coin_acceptor;

    localparam int TO = 20;
    localparam int P0 = 4;
    localparam int P1 = 28;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       coin_det  = 1'b0;
    logic [1:0] coin_val  = 2'd0;
    logic       cancel    = 1'b0;
    logic       wash_done = 1'b0;

    logic       coin_in_o [2];
    logic [4:0] credit_o  [2];
    logic       busy_o    [2];
    logic       cv_o      [2];
    logic [4:0] amt_o     [2];
    logic       rej_o     [2];

    always #5 clk = ~clk;

    coin_acceptor #(.PRICE(P0), .TIMEOUT_CYC(TO)) dut0 (
        .clk(clk), .rst_n(rst_n), .coin_det(coin_det), .coin_val(coin_val),
        .cancel(cancel), .wash_done(wash_done), .coin_in(coin_in_o[0]),
        .credit(credit_o[0]), .busy(busy_o[0]), .change_valid(cv_o[0]),
        .change_amt(amt_o[0]), .coin_reject(rej_o[0])
    );

    coin_acceptor #(.PRICE(P1), .TIMEOUT_CYC(TO)) dut1 (
        .clk(clk), .rst_n(rst_n), .coin_det(coin_det), .coin_val(coin_val),
        .cancel(cancel), .wash_done(wash_done), .coin_in(coin_in_o[1]),
        .credit(credit_o[1]), .busy(busy_o[1]), .change_valid(cv_o[1]),
        .change_amt(amt_o[1]), .coin_reject(rej_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: what each machine shows after every clock edge.
    int price [2] = '{P0, P1};
    int m_credit [2];
    int m_idle   [2];
    int m_amt    [2];
    bit m_busy   [2];
    bit m_start  [2];
    bit m_done_seen [2];
    bit m_cv     [2];
    bit m_rej    [2];
    bit m_prev;
    bit m_armed;

    function automatic int denom(input logic [1:0] code);
        case (code)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 5;
            default: return 10;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_credit[i] = 0; m_idle[i] = 0; m_amt[i] = 0; m_busy[i] = 0;
            m_start[i] = 0; m_done_seen[i] = 0; m_cv[i] = 0; m_rej[i] = 0;
        end
        m_prev  = 0;
        m_armed = 0;
    endfunction

    function automatic void pay(input int i, input int amount);
        m_cv[i]     = 1;
        m_amt[i]    = amount;
        m_credit[i] = 0;
        m_idle[i]   = 0;
    endfunction

    function automatic void model_step();
        bit evt;
        int cv;
        int total;
        bit was_start;
        evt     = coin_det && !m_prev && m_armed;
        m_prev  = coin_det;
        m_armed = 1;
        cv      = denom(coin_val);
        for (int i = 0; i < 2; i++) begin
            was_start  = m_start[i];
            m_start[i] = 0; m_cv[i] = 0; m_amt[i] = 0; m_rej[i] = 0;
            if (was_start) begin
                m_rej[i]  = evt;
                m_busy[i] = 1;
            end else if (m_busy[i]) begin
                m_rej[i] = evt;
                if (!m_done_seen[i]) m_done_seen[i] = wash_done;
                else if (!wash_done) begin
                    m_busy[i] = 0;
                    m_done_seen[i] = 0;
                end
            end else if (m_credit[i] >= price[i]) begin
                m_start[i] = 1;
                m_rej[i]   = evt;
                if (m_credit[i] > price[i]) pay(i, m_credit[i] - price[i]);
                m_credit[i] = 0;
                m_idle[i]   = 0;
            end else begin
                total = m_credit[i] + (evt ? cv : 0);
                if (evt && total > 31) begin
                    m_rej[i] = 1;
                    total = m_credit[i];
                end
                if (cancel && total > 0) pay(i, total);
                else if (!evt && m_credit[i] > 0 && m_idle[i] == TO - 1) pay(i, m_credit[i]);
                else begin
                    m_idle[i]   = (evt || m_credit[i] == 0) ? 0 : m_idle[i] + 1;
                    m_credit[i] = total;
                end
            end
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("credit[%0d]", i),   32'(credit_o[i]),  32'(m_credit[i]));
            check($sformatf("busy[%0d]", i),     32'(busy_o[i]),    32'(m_busy[i]));
            check($sformatf("coin_in[%0d]", i),  32'(coin_in_o[i]), 32'(m_start[i]));
            check($sformatf("chg_vld[%0d]", i),  32'(cv_o[i]),      32'(m_cv[i]));
            check($sformatf("chg_amt[%0d]", i),  32'(amt_o[i]),     32'(m_amt[i]));
            check($sformatf("reject[%0d]", i),   32'(rej_o[i]),     32'(m_rej[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        compare_all();
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge, then released.
    task automatic do_reset(input bit det_hi);
        #2;
        rst_n     = 1'b0;
        coin_det  = det_hi;
        cancel    = 1'b0;
        wash_done = 1'b0;
        model_reset();
        #1;
        check("rst_busy",    32'(busy_o[0]),    32'd0);
        check("rst_coin_in", 32'(coin_in_o[0]), 32'd0);
        check("rst_credit",  32'(credit_o[0]),  32'd0);
        compare_all();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic coin(input logic [1:0] code);
        coin_det = 1'b1;
        coin_val = code;
        tick();
        coin_det = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        model_reset();
        do_reset(1'b0);

        // 2 + 2 reaches the price: start pulse two cycles after the second edge.
        coin(2'd1);
        coin(2'd1);
        check("c22_coin_in", 32'(coin_in_o[0]), 32'd1);
        check("c22_no_chg",  32'(cv_o[0]),      32'd0);
        check("c22_credit",  32'(credit_o[0]),  32'd0);
        tick();
        check("c22_busy_run", 32'(busy_o[0]), 32'd1);
        wash_done = 1'b1;
        tick();
        tick();
        check("c22_busy_wait", 32'(busy_o[0]), 32'd1);
        wash_done = 1'b0;
        tick();
        check("c22_idle", 32'(busy_o[0]), 32'd0);

        // A single 5 overpays by one unit.
        coin(2'd2);
        check("c5_coin_in", 32'(coin_in_o[0]), 32'd1);
        check("c5_chg_vld", 32'(cv_o[0]),      32'd1);
        check("c5_chg_amt", 32'(amt_o[0]),     32'd1);
        check("c5_credit",  32'(credit_o[0]),  32'd0);
        tick();

        // Coin during a wash is refused.
        coin_det = 1'b1;
        coin_val = 2'd1;
        tick();
        check("run_reject", 32'(rej_o[0]),    32'd1);
        check("run_credit", 32'(credit_o[0]), 32'd0);
        coin_det  = 1'b0;
        wash_done = 1'b1;
        tick();
        wash_done = 1'b0;
        tick();
        tick();

        // 1 + 2 then cancel refunds 3.
        coin(2'd0);
        coin(2'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_vld",     32'(cv_o[0]),      32'd1);
        check("cancel_amt",     32'(amt_o[0]),     32'd3);
        check("cancel_credit",  32'(credit_o[0]),  32'd0);
        check("cancel_coin_in", 32'(coin_in_o[0]), 32'd0);
        tick();

        // Overflow past 31 refused on the high-price instance.
        do_reset(1'b0);
        coin(2'd3);
        coin(2'd3);
        coin(2'd2);
        check("ovf_credit25", 32'(credit_o[1]), 32'd25);
        coin_det = 1'b1;
        coin_val = 2'd3;
        tick();
        check("ovf_reject", 32'(rej_o[1]),    32'd1);
        check("ovf_credit", 32'(credit_o[1]), 32'd25);
        coin_det = 1'b0;
        tick();

        // Idle timeout refund of a single unit.
        do_reset(1'b0);
        coin(2'd0);
        cycles = 1;
        while (!cv_o[0] && cycles < TO + 10) begin
            tick();
            cycles++;
        end
        check("to_cycles", 32'(cycles),      32'(TO));
        check("to_amt",    32'(amt_o[0]),    32'd1);
        check("to_credit", 32'(credit_o[0]), 32'd0);
        check("to_busy",   32'(busy_o[0]),   32'd0);
        tick();

        // Reset during a wash, then counting restarts from zero.
        coin(2'd2);
        tick();
        check("rrun_busy", 32'(busy_o[0]), 32'd1);
        do_reset(1'b0);
        coin(2'd1);
        check("rrun_recount", 32'(credit_o[0]), 32'd2);

        // coin_det already high when reset releases is not a coin.
        do_reset(1'b1);
        tick();
        tick();
        check("det_hi_credit", 32'(credit_o[0]), 32'd0);
        check("det_hi_reject", 32'(rej_o[0]),    32'd0);
        coin_det = 1'b0;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            coin_det  = ($urandom_range(0, 2) == 0);
            coin_val  = 2'($urandom_range(0, 3));
            cancel    = ($urandom_range(0, 19) == 0);
            wash_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) do_reset(1'($urandom_range(0, 1)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter PRICE, default 4, credit units per wash.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000, idle cycles with partial credit before auto-refund.
REQ-003 SHALL have port clk, input, 1, single clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port coin_det, input, 1, coin sensor; one rising edge per coin.
REQ-006 SHALL have port coin_val, input, 2, coin denomination sampled with coin_det edge: 00=1, 01=2, 10=5, 11=10 units.
REQ-007 SHALL have port cancel, input, 1, user cancel/refund request, level.
REQ-008 SHALL have port wash_done, input, 1, completion level from washing-machine controller.
REQ-009 SHALL have port coin_in, output, 1, one-cycle start pulse to washing-machine controller.
REQ-010 SHALL have port credit, output, 5, current accumulated credit.
REQ-011 SHALL have port busy, output, 1, high while a wash is in progress.
REQ-012 SHALL have port change_valid, output, 1, one-cycle pulse qualifying change_amt.
REQ-013 SHALL have port change_amt, output, 5, refund/change value; 0 when change_valid low.
REQ-014 SHALL have port coin_reject, output, 1, one-cycle pulse when a coin is refused.

Function
REQ-015 SHALL detect coin events as rising edges of coin_det (internal previous-value flop); coin_val is taken on the edge cycle.
REQ-016 SHALL implement states ACCUM, START, RUN, WAIT_CLR.
REQ-017 ACCUM: each accepted coin adds its value to credit in the cycle after the edge; idle counter clears on each coin.
REQ-018 ACCUM: a coin that would make credit exceed 31 SHALL be refused (coin_reject pulse, credit unchanged).
REQ-019 ACCUM: when credit >= PRICE, next state START.
REQ-020 START (one cycle): coin_in=1; credit <= 0; if credit-PRICE > 0, change_valid=1 and change_amt=credit-PRICE in same cycle; next RUN.
REQ-021 RUN: busy=1; every coin edge refused with coin_reject; cancel ignored; on wash_done=1 next WAIT_CLR.
REQ-022 WAIT_CLR: busy=1; stay until wash_done=0, then ACCUM.
REQ-023 ACCUM with credit>0 and cancel=1: change_valid=1, change_amt=credit, credit <= 0; cancel with credit=0 has no effect.
REQ-024 Cancel and coin edge in same ACCUM cycle: coin value SHALL be included in refund (change_amt=credit+coin value), subject to REQ-018.
REQ-025 Idle counter SHALL increment each ACCUM cycle with 0 < credit < PRICE and no coin; at TIMEOUT_CYC-1 it refunds as REQ-023 and clears.
REQ-026 Cancel SHALL take priority over reaching PRICE only if asserted in the same cycle the final coin arrives.
REQ-027 Latency coin edge -> coin_in SHALL be exactly 2 cycles when the coin completes the price (without REQ-033).

Reset
REQ-028 rst_n low SHALL immediately force state ACCUM, credit=0, idle counter=0, edge flop=0.
REQ-029 Reset outputs: coin_in=0, busy=0, change_valid=0, change_amt=0, coin_reject=0.
REQ-030 Reset mid-wash SHALL discard credit without issuing change.
REQ-031 coin_det high at reset release SHALL NOT count as a coin.

Configuration
REQ-032 Macro COIN_SYNC_EN SHALL select optional input synchronizer.
REQ-033 With COIN_SYNC_EN defined: coin_det, coin_val, cancel pass through a 2-flop synchronizer before use; REQ-027 latency becomes 4 cycles.
REQ-034 Without COIN_SYNC_EN: inputs used directly, no extra flops.

Structure
REQ-035 Package coin_acceptor_pkg SHALL hold the state encoding, coin denomination constants, CREDIT_W=5, CREDIT_MAX=31.
REQ-036 Sub-module coin_edge_detect SHALL contain the optional synchronizer and rising-edge detector.

Verification
REQ-037 Coins 2,2 (PRICE=4) -> coin_in pulse 2 cycles after 2nd edge, no change_valid, busy=1 until wash_done falls.
REQ-038 Coin 5 -> coin_in pulse with change_valid=1, change_amt=1 same cycle; credit=0.
REQ-039 Coin 1, 2, then cancel -> change_valid=1, change_amt=3, credit=0, no coin_in.
REQ-040 Coin 2 in RUN -> coin_reject pulse, credit stays 0; credit 25 + coin 10 -> coin_reject, credit 25.
REQ-041 Coin 1 then no activity TIMEOUT_CYC cycles -> change_amt=1 refund, state ACCUM.
REQ-042 rst_n low during RUN -> busy=0, coin_in=0 asynchronously; later coins counted from 0.
